// File: rtl/tdm_demux16.sv
// Receive side of the 16-channel TDM path: collects one sample per valid beat
// into a staging register and publishes the whole frame when slot 15 arrives.
module tdm_demux16 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in,
    input  logic                  in_valid,
    input  logic                  sof,
    output logic [16*WIDTH-1:0]   out,
    output logic                  out_valid,
    output logic [3:0]            sel,
    output logic                  err
);

    localparam int unsigned NSTAGE = 15;
    localparam logic [3:0]  LAST   = 4'd15;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                    state;
    // Slot 15 is never staged: it goes straight to out with the publish.
    logic [NSTAGE*WIDTH-1:0]   stage;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            stage     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            sel       <= 4'd0;
        end else begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            if (in_valid) begin
                case (state)
                    IDLE: begin
                        if (sof) begin
                            stage[WIDTH-1:0] <= in;
                            sel              <= 4'd1;
                            state            <= RUN;
                        end
                    end
                    RUN: begin
                        if (sof) begin
                            // Resync: drop the partial frame, this beat is slot 0.
                            err              <= 1'b1;
                            stage[WIDTH-1:0] <= in;
                            sel              <= 4'd1;
                        end else if (sel == LAST) begin
                            out       <= {in, stage};
                            out_valid <= 1'b1;
                            sel       <= 4'd0;
                            state     <= IDLE;
                        end else begin
                            for (int unsigned k = 0; k < NSTAGE; k++) begin
                                if (sel == 4'(k)) begin
                                    stage[k*WIDTH +: WIDTH] <= in;
                                end
                            end
                            sel <= sel + 4'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux16.sv
// Scoreboard bench for tdm_demux16 at WIDTH=1 and WIDTH=4.
module tb_tdm_demux16;

    logic        clk;
    logic        rst;
    logic        in1, iv1, sof1, ov1, err1;
    logic [15:0] out1;
    logic [3:0]  sel1;
    logic [3:0]  in4;
    logic        iv4, sof4, ov4, err4;
    logic [63:0] out4;
    logic [3:0]  sel4;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nerr1 = 0;
    int nerr4 = 0;
    logic [63:0] q1[$];
    logic [63:0] q4[$];
    int          ts1[$];

    tdm_demux16 #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .in(in1), .in_valid(iv1), .sof(sof1),
        .out(out1), .out_valid(ov1), .sel(sel1), .err(err1)
    );

    tdm_demux16 #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .in(in4), .in_valid(iv4), .sof(sof4),
        .out(out4), .out_valid(ov4), .sel(sel4), .err(err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] cur_sel(input int d);
        return (d == 0) ? sel1 : sel4;
    endfunction

    function automatic logic cur_err(input int d);
        return (d == 0) ? err1 : err4;
    endfunction

    function automatic logic [63:0] cur_out(input int d);
        return (d == 0) ? 64'(out1) : out4;
    endfunction

    // Monitor: pop expected frame on every out_valid, count err pulses.
    always @(negedge clk) begin
        logic [63:0] e;
        if (ov1 || err1) chk("w1 out_valid and err together", 64'(ov1 & err1), 64'd0);
        if (ov4 || err4) chk("w4 out_valid and err together", 64'(ov4 & err4), 64'd0);
        if (err1) nerr1++;
        if (err4) nerr4++;
        if (ov1) begin
            ts1.push_back(cyc);
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL w1 unexpected out_valid: got out=%0h expected no frame", out1);
            end else begin
                e = q1.pop_front();
                chk("w1 out", 64'(out1), e);
            end
        end
        if (ov4) begin
            if (q4.size() == 0) begin
                total++; bad++;
                $display("FAIL w4 unexpected out_valid: got out=%0h expected no frame", out4);
            end else begin
                e = q4.pop_front();
                chk("w4 out", out4, e);
            end
        end
    end

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int d, input logic [3:0] v, input bit s);
        if (d == 0) begin in1 = v[0]; sof1 = s; iv1 = 1'b1; end
        else        begin in4 = v;    sof4 = s; iv4 = 1'b1; end
        @(posedge clk);
        #1;
        iv1 = 1'b0; iv4 = 1'b0; sof1 = 1'b0; sof4 = 1'b0;
    endtask

    // Sends nbeats slots of pat starting at slot 0; abort=1 expects this sof to cut a frame.
    task automatic send_frame(input int d, input logic [63:0] pat, input int nbeats,
                              input int gap, input bit abort, input bit push,
                              input logic [63:0] keep);
        logic [3:0] v;
        logic [3:0] es;
        if (push) begin
            if (d == 0) q1.push_back(pat);
            else        q4.push_back(pat);
        end
        for (int k = 0; k < nbeats; k++) begin
            if (k > 0 || !abort) chk("sel before beat", 64'(cur_sel(d)), 64'(k));
            v = (d == 0) ? 4'(pat[k]) : pat[k*4 +: 4];
            beat(d, v, k == 0);
            if (abort && k == 0) begin
                chk("err after abort sof", 64'(cur_err(d)), 64'd1);
                chk("out untouched by abort", cur_out(d), keep);
            end
            if (abort && k == 1) chk("err one cycle", 64'(cur_err(d)), 64'd0);
            es = (k == 15) ? 4'd0 : 4'(k + 1);
            for (int g = 0; g < gap; g++) begin
                idle();
                chk("sel holds in gap", 64'(cur_sel(d)), 64'(es));
            end
        end
        if (nbeats == 16) chk("sel back to 0", 64'(cur_sel(d)), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        in1 = 1'b0; iv1 = 1'b0; sof1 = 1'b0;
        in4 = 4'd0; iv4 = 1'b0; sof4 = 1'b0;

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            in1 = 1'($urandom); iv1 = 1'($urandom); sof1 = 1'($urandom);
            in4 = 4'($urandom); iv4 = 1'($urandom); sof4 = 1'($urandom);
            idle();
            chk("rst out1", 64'(out1), 64'd0);
            chk("rst ov1", 64'(ov1), 64'd0);
            chk("rst err1", 64'(err1), 64'd0);
            chk("rst sel1", 64'(sel1), 64'd0);
            chk("rst out4", out4, 64'd0);
            chk("rst sel4", 64'(sel4), 64'd0);
        end
        iv1 = 1'b0; sof1 = 1'b0; iv4 = 1'b0; sof4 = 1'b0;
        rst = 1'b0;
        idle();
        chk("post-rst out1", 64'(out1), 64'd0);
        chk("post-rst ov1", 64'(ov1), 64'd0);
        chk("post-rst err1", 64'(err1), 64'd0);
        chk("post-rst sel1", 64'(sel1), 64'd0);

        // Single frame, then same frame with 3-cycle gaps
        send_frame(0, 64'hA5C3, 16, 0, 1'b0, 1'b1, 64'd0);
        idle();
        send_frame(0, 64'hA5C3, 16, 3, 1'b0, 1'b1, 64'd0);
        repeat (3) idle();

        // Abort: 7 beats of A then sof with B
        send_frame(0, 64'h5A5A, 7, 0, 1'b0, 1'b0, 64'd0);
        send_frame(0, 64'h1234, 16, 0, 1'b1, 1'b1, 64'hA5C3);
        repeat (3) idle();
        chk("w1 out after abort frame", 64'(out1), 64'h1234);

        // Junk while IDLE, then back-to-back frames
        for (int i = 0; i < 5; i++) begin
            beat(0, 4'(i), 1'b0);
            chk("junk err", 64'(err1), 64'd0);
            chk("junk sel", 64'(sel1), 64'd0);
        end
        send_frame(0, 64'hFFFF, 16, 0, 1'b0, 1'b1, 64'd0);
        send_frame(0, 64'h0001, 16, 0, 1'b0, 1'b1, 64'd0);
        repeat (3) idle();
        if (ts1.size() >= 2) chk("b2b spacing", 64'(ts1[ts1.size()-1] - ts1[ts1.size()-2]), 64'd16);
        else chk("b2b pulse count", 64'(ts1.size()), 64'd2);

        // WIDTH=4: ramp frame, then reset in the middle of the next frame
        send_frame(1, 64'hFEDCBA9876543210, 16, 0, 1'b0, 1'b1, 64'd0);
        repeat (2) idle();
        chk("w4 out ramp", out4, 64'hFEDCBA9876543210);
        send_frame(1, 64'h0123456789ABCDEF, 9, 0, 1'b0, 1'b0, 64'd0);
        chk("w4 sel at slot 9", 64'(sel4), 64'd9);
        in4 = 4'd9; sof4 = 1'b0; iv4 = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("w4 async rst out", out4, 64'd0);
        chk("w4 async rst sel", 64'(sel4), 64'd0);
        idle();
        iv4 = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            beat(1, 4'(i + 10), 1'b0);
        end
        repeat (20) idle();
        chk("w4 out stays cleared", out4, 64'd0);
        chk("w4 sel stays idle", 64'(sel4), 64'd0);

        chk("w1 frames left", 64'(q1.size()), 64'd0);
        chk("w4 frames left", 64'(q4.size()), 64'd0);
        chk("w1 err pulses", 64'(nerr1), 64'd1);
        chk("w4 err pulses", 64'(nerr4), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux16.md
# tdm_demux16

Time-division demultiplexer: receiving end of the 16-channel mux path. Accepts a serial stream of channel samples, one per valid beat, with a start-of-frame marker on channel 0. Steers each sample into its slot of a staging register and publishes all 16 channels atomically once a frame completes. Slot k of the output corresponds to mux input I[k] selected with sel = k on the transmitting side.

## Interface
- WIDTH, 1, bits per channel sample
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in  input  WIDTH  channel sample for the current slot
- in_valid  input  1  in carries a sample this cycle
- sof  input  1  start of frame; qualifies in as slot 0; ignored unless in_valid=1
- out  output  16*WIDTH  last complete frame; slot k at out[k*WIDTH +: WIDTH]
- out_valid  output  1  one-cycle pulse: out updated with a new frame
- sel  output  4  slot index the next accepted beat will be written to
- err  output  1  one-cycle pulse: frame aborted (sof received mid-frame)

## Operation
- States: IDLE (waiting for sof), RUN (collecting slots 1..15).
- Beat = cycle with in_valid=1. Cycles with in_valid=0 change nothing (no state, sel or staging change); gaps of any length allowed inside a frame.
- IDLE:
  - beat with sof=1: staging slot 0 <= in, sel <= 1, go to RUN.
  - beat with sof=0: discarded, no error, stay IDLE, sel stays 0.
- RUN:
  - beat with sof=0, sel<15: staging slot sel <= in, sel <= sel+1.
  - beat with sof=0, sel=15: out <= staging with slot 15 replaced by in, out_valid pulses, sel <= 0, go to IDLE.
  - beat with sof=1, any sel: err pulses, partial frame discarded, beat taken as slot 0 of a new frame (staging slot 0 <= in, sel <= 1, stay RUN). out is not touched.
- out only changes on frame completion; a partial or aborted frame never reaches out. Stale staging slots need not be cleared, because every slot is rewritten before the next publish.
- sel is a 4-bit counter. It never wraps from 15 to 0 by increment; the return to 0 happens only through frame completion or reset.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Reset values: out=0, out_valid=0, err=0, sel=0, staging=0, state=IDLE. Asserting rst mid-frame discards the partial frame immediately; out returns to 0.
- Latency: the slot-15 beat sampled at edge t appears on out, with out_valid=1, in the cycle after edge t. out_valid is high for exactly that one cycle.
- Back-to-back frames: a sof beat in the cycle right after the slot-15 beat is accepted as slot 0, with no bubble required. Sustained throughput is one frame per 16 beats.
- err is high for exactly one cycle after the offending sof beat. out_valid and err are never high in the same cycle.
- sel reflects state after each edge. It reads 0 in IDLE and 1..15 in RUN.

## Test plan
- Reset: hold rst=1 with random inputs, then release. Required: out=0, out_valid=0, err=0, sel=0 through reset and in the first cycle after release.
- Single frame, WIDTH=1: 16 consecutive beats of the pattern 0xA5C3, LSB (slot 0) first, sof on beat 0. Required: out=16'hA5C3 and out_valid=1 for one cycle, in the cycle after beat 15. sel must step 0,1,..,15,0.
- Gaps: the same frame with in_valid deasserted for 3 cycles between each pair of beats. Required: identical out. sel holds during gaps. Exactly one out_valid pulse.
- Abort: 7 beats of frame A, then sof with frame B (16 beats, 0x1234). Required: err pulses once, after the sof beat. out=16'h1234. No out_valid after the abort until frame B completes.
- Junk before sync and back-to-back: 5 beats without sof while IDLE, then frames 0xFFFF and 0x0001 with no gap. Required: junk ignored with no err. Two out_valid pulses 16 cycles apart carrying 0xFFFF then 0x0001.
- WIDTH=4 with a mid-frame reset: a frame with slot k = k, then rst at slot 9 of a second frame. Required: first frame gives out=64'hFEDCBA9876543210. Reset clears out to 0, and no out_valid is produced for the second frame.
